uart_hex_sender: RTL and testbench

//  Consumer of the monitor read-data path. On a send pulse it captures a 64-bit dump word or a 32-bit PC value.
//  It formats the value as lowercase ASCII hex, adds separators and CR/LF, and pushes the bytes into the UART TX queue.

---
 rtl/uart_hex_sender.sv | 153 +++++++++++++++
 tb/tb_uart_hex_sender.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_sender.sv
// uart_hex_sender
// Captures a 64-bit dump word (two 32-bit halves) or a 32-bit PC value on a
// send request. The value is sent as ASCII hex with a separator and CR/LF,
// one byte per cycle, into the UART TX queue. Once the queue reports empty,
// a single flushing_wq pulse tells the dump sequencer the line is out.
module uart_hex_sender #(
  parameter bit         HEX_UPPER = 1'b0,
  parameter logic [7:0] SEP_CHAR  = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdata_snd_start,
  input  logic [63:0] rdata_snd,
  input  logic        pc_print_sel,
  input  logic        snd_abort,
  input  logic        tx_full,
  input  logic        tx_empty,
  output logic [7:0]  tx_data,
  output logic        tx_wen,
  output logic        flushing_wq,
  output logic        snd_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [4:0]  r_idx;
  logic [4:0]  w_next_idx;
  logic [63:0] r_shadow;
  logic        r_mode;       // 1 = PC mode, 0 = dump mode

  logic [4:0]  w_last_idx;
  logic        w_is_hex;
  logic [3:0]  w_nib_pos;
  logic [3:0]  w_nibble;
  logic [7:0]  w_fixed;
  logic [7:0]  w_char;
  logic [2:0]  w_hi_off;

  // Map one nibble to its ASCII hex digit.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'b0000, n};
    else           return (HEX_UPPER ? 8'h41 : 8'h61) + {4'b0000, n} - 8'd10;
  endfunction

  assign w_last_idx = r_mode ? 5'd9 : 5'd18;

  // For idx 9..16 the data_1 nibble number is 16-idx; since 16 is a multiple
  // of 8, its low three bits are simply the negated low bits of idx.
  assign w_hi_off = 3'd0 - r_idx[2:0];

  // Character selection for the current idx.
  // NOTE: every signal written in always_comb gets a default first, so no path
  // can leave one unassigned and infer a latch.
  always_comb begin
    w_is_hex  = 1'b0;
    w_nib_pos = 4'd0;
    w_fixed   = 8'h00;
    if (r_idx <= 5'd7) begin
      w_is_hex  = 1'b1;
      w_nib_pos = {1'b0, 3'd7 - r_idx[2:0]};
    end else if (r_mode) begin
      w_fixed = (r_idx == 5'd8) ? 8'h0D : 8'h0A;
    end else if (r_idx == 5'd8) begin
      w_fixed = SEP_CHAR;
    end else if (r_idx <= 5'd16) begin
      w_is_hex  = 1'b1;
      w_nib_pos = {1'b1, w_hi_off};
    end else begin
      w_fixed = (r_idx == 5'd17) ? 8'h0D : 8'h0A;
    end
    w_nibble = r_shadow[{w_nib_pos, 2'b00} +: 4];
    w_char   = w_is_hex ? hex_char(w_nibble) : w_fixed;
  end

  // Outputs are decoded straight from state so reset drives them all low.
  assign tx_wen      = (r_state == SEND) & ~tx_full & ~snd_abort;
  assign tx_data     = (r_state == SEND) ? w_char : 8'h00;
  assign flushing_wq = (r_state == DONE);
  assign snd_busy    = (r_state != IDLE);

  // Next-state and next-index logic; abort overrides everything but IDLE.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    case (r_state)
      IDLE: begin
        if (rdata_snd_start) begin
          w_next_state = SEND;
          w_next_idx   = 5'd0;
        end
      end
      SEND: begin
        if (tx_wen) begin
          if (r_idx == w_last_idx) begin
            w_next_state = FLUSH;
            w_next_idx   = 5'd0;
          end else begin
            w_next_idx = r_idx + 5'd1;
          end
        end
      end
      FLUSH: begin
        if (tx_empty) w_next_state = DONE;
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
        w_next_idx   = 5'd0;
      end
    endcase
    // The DONE pulse is already on the output this cycle, so abort there
    // cannot suppress it; it only changes where we go next (IDLE either way).
    if (snd_abort && (r_state != IDLE)) begin
      w_next_state = IDLE;
      w_next_idx   = 5'd0;
    end
  end

  // State and index registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= 5'd0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
    end
  end

  // Shadow capture: only a start seen in IDLE loads the payload and mode, so
  // upstream may change rdata_snd freely once the send is under way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= 64'd0;
      r_mode   <= 1'b0;
    end else if ((r_state == IDLE) && rdata_snd_start) begin
      r_shadow <= rdata_snd;
      r_mode   <= pc_print_sel;
    end
  end

endmodule

// File: tb/tb_uart_hex_sender.sv
// Self-checking bench for uart_hex_sender. Two instances (lowercase and
// uppercase hex) share all inputs; the expected byte stream is produced from
// formatted strings, and handshake timing is predicted per cycle.
module tb_uart_hex_sender;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdata_snd_start;
  logic [63:0] rdata_snd;
  logic        pc_print_sel;
  logic        snd_abort;
  logic        tx_full;
  logic        tx_empty;

  logic [7:0]  lo_tx_data, up_tx_data;
  logic        lo_tx_wen, up_tx_wen;
  logic        lo_flush, up_flush;
  logic        lo_busy, up_busy;

  int n_vec = 0;
  int n_err = 0;

  byte unsigned exp_lo[$];
  byte unsigned exp_up[$];

  always #5 clk = ~clk;

  uart_hex_sender #(.HEX_UPPER(1'b0), .SEP_CHAR(8'h20)) u_dut_lo (
    .clk(clk), .rst_n(rst_n), .rdata_snd_start(rdata_snd_start),
    .rdata_snd(rdata_snd), .pc_print_sel(pc_print_sel), .snd_abort(snd_abort),
    .tx_full(tx_full), .tx_empty(tx_empty), .tx_data(lo_tx_data),
    .tx_wen(lo_tx_wen), .flushing_wq(lo_flush), .snd_busy(lo_busy)
  );

  uart_hex_sender #(.HEX_UPPER(1'b1), .SEP_CHAR(8'h20)) u_dut_up (
    .clk(clk), .rst_n(rst_n), .rdata_snd_start(rdata_snd_start),
    .rdata_snd(rdata_snd), .pc_print_sel(pc_print_sel), .snd_abort(snd_abort),
    .tx_full(tx_full), .tx_empty(tx_empty), .tx_data(up_tx_data),
    .tx_wen(up_tx_wen), .flushing_wq(up_flush), .snd_busy(up_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected message as text: data_0, separator, data_1 (or just the PC), CR, LF.
  task automatic build_model(input logic [63:0] v, input bit pc);
    string s_lo;
    string s_up;
    if (pc) s_lo = $sformatf("%08x", v[31:0]);
    else    s_lo = $sformatf("%08x %08x", v[31:0], v[63:32]);
    s_up = s_lo.toupper();
    exp_lo.delete();
    exp_up.delete();
    for (int i = 0; i < s_lo.len(); i++) begin
      exp_lo.push_back(s_lo[i]);
      exp_up.push_back(s_up[i]);
    end
    exp_lo.push_back(8'h0D); exp_lo.push_back(8'h0A);
    exp_up.push_back(8'h0D); exp_up.push_back(8'h0A);
  endtask

  task automatic check_quiet(input string tag, input logic busy);
    check({tag, " busy_lo"}, lo_busy, busy);
    check({tag, " busy_up"}, up_busy, busy);
    check({tag, " flush_lo"}, lo_flush, 1'b0);
    check({tag, " wen_lo"}, lo_tx_wen, 1'b0);
    check({tag, " data_lo"}, lo_tx_data, 8'h00);
  endtask

  // One send transaction. Called at posedge+1 with the DUTs idle.
  task automatic do_send(input logic [63:0] v, input bit pc, input int stall_at,
                         input int stall_len, input bit rand_full, input int abort_at,
                         input int dup_at, input bit rst_flush, input string tag);
    int  len, n, cyc, fulls, stall_left, last_cyc, wait_c;
    bit  exp_wen, aborted, dup_done;
    build_model(v, pc);
    len = exp_lo.size();
    n = 0; cyc = 0; fulls = 0; stall_left = stall_len; last_cyc = 0;
    aborted = 1'b0; dup_done = 1'b0;

    rdata_snd = v; pc_print_sel = pc; rdata_snd_start = 1'b1;
    tx_empty = 1'b0; tx_full = 1'b0; snd_abort = 1'b0;
    @(posedge clk); #1;
    rdata_snd_start = 1'b0;
    rdata_snd = {$urandom, $urandom};
    pc_print_sel = 1'($urandom);

    while (n < len && cyc < 200) begin
      cyc++;
      tx_full = 1'b0; snd_abort = 1'b0; rdata_snd_start = 1'b0;
      if (stall_at >= 0 && n == stall_at && stall_left > 0) begin
        tx_full = 1'b1;
        stall_left--;
      end else if (rand_full && $urandom_range(0, 3) == 0) begin
        tx_full = 1'b1;
      end
      if (n == abort_at) snd_abort = 1'b1;
      if (n == dup_at && !dup_done) begin
        rdata_snd_start = 1'b1;
        rdata_snd = {$urandom, $urandom};
        pc_print_sel = ~pc;
        dup_done = 1'b1;
      end
      exp_wen = !tx_full && !snd_abort;
      @(negedge clk);
      check($sformatf("%s wen_lo[%0d]", tag, n), lo_tx_wen, exp_wen);
      check($sformatf("%s wen_up[%0d]", tag, n), up_tx_wen, exp_wen);
      check($sformatf("%s data_lo[%0d]", tag, n), lo_tx_data, exp_lo[n]);
      check($sformatf("%s data_up[%0d]", tag, n), up_tx_data, exp_up[n]);
      check($sformatf("%s busy[%0d]", tag, n), lo_busy, 1'b1);
      check($sformatf("%s flush[%0d]", tag, n), lo_flush, 1'b0);
      if (tx_full) fulls++;
      if (exp_wen) begin
        n++;
        last_cyc = cyc;
      end
      @(posedge clk); #1;
      if (snd_abort) begin
        aborted = 1'b1;
        break;
      end
    end
    tx_full = 1'b0; snd_abort = 1'b0; rdata_snd_start = 1'b0;

    if (aborted) begin
      // Abort: back in IDLE immediately, and no drain pulse ever follows.
      tx_empty = 1'b1;
      repeat (3) begin
        @(negedge clk);
        check_quiet({tag, " post_abort"}, 1'b0);
        @(posedge clk); #1;
      end
      return;
    end

    check({tag, " byte_count"}, n, len);
    check({tag, " last_write_cycle"}, last_cyc, len + fulls);

    wait_c = $urandom_range(0, 2);
    repeat (wait_c) begin
      @(negedge clk);
      check_quiet({tag, " flush_wait"}, 1'b1);
      @(posedge clk); #1;
    end

    if (rst_flush) begin
      #1 rst_n = 1'b0;
      #1;
      check_quiet({tag, " in_reset"}, 1'b0);
      check({tag, " in_reset busy_up"}, up_busy, 1'b0);
      check({tag, " in_reset flush_up"}, up_flush, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tx_empty = 1'b1;
      repeat (3) begin
        @(negedge clk);
        check_quiet({tag, " after_reset"}, 1'b0);
        @(posedge clk); #1;
      end
      return;
    end

    tx_empty = 1'b1;
    @(negedge clk);
    check({tag, " flush_pre"}, lo_flush, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, " flush_pulse_lo"}, lo_flush, 1'b1);
    check({tag, " flush_pulse_up"}, up_flush, 1'b1);
    check({tag, " flush_busy"}, lo_busy, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check_quiet({tag, " flush_post"}, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    rdata_snd_start = 1'b0;
    rdata_snd = 64'd0;
    pc_print_sel = 1'b0;
    snd_abort = 1'b0;
    tx_full = 1'b0;
    tx_empty = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset", 1'b0);
    check("reset busy_up", up_busy, 1'b0);
    check("reset wen_up", up_tx_wen, 1'b0);
    check("reset flush_up", up_flush, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_send(64'h89ABCDEF_01234567, 1'b0, -1, 0, 1'b0, -1, -1, 1'b0, "T1");
    do_send(64'hDEADBEEF_000001FC, 1'b1, -1, 0, 1'b0, -1, -1, 1'b0, "T2");
    do_send(64'h89ABCDEF_01234567, 1'b0, 5, 3, 1'b0, -1, -1, 1'b0, "T3");
    do_send(64'h0F1E2D3C_4B5A6978, 1'b0, -1, 0, 1'b0, 10, -1, 1'b0, "T4");
    do_send({$urandom, $urandom}, 1'b0, -1, 0, 1'b0, -1, -1, 1'b0, "T4_restart");
    do_send(64'h13579BDF_2468ACE0, 1'b0, -1, 0, 1'b0, -1, 4, 1'b0, "T5_dup");
    do_send(64'hFFFFFFFF_AAAAAAAA, 1'b0, -1, 0, 1'b0, -1, -1, 1'b0, "T5_upper");
    do_send(64'hCAFEF00D_12345678, 1'b0, -1, 0, 1'b0, -1, -1, 1'b1, "T6");
    do_send(64'h00000000_ABCDEF09, 1'b1, -1, 0, 1'b0, -1, -1, 1'b0, "T6_after");

    for (int k = 0; k < 12; k++) begin
      do_send({$urandom, $urandom}, 1'($urandom), -1, 0, 1'b1,
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : -1,
              -1, 1'b0, $sformatf("R%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
